adder_delay_meter: RTL and testbench



---
 rtl/adder_meas_pkg.sv | 32 +++
 rtl/meas_edge_sync.sv | 43 ++++
 rtl/adder_delay_meter.sv | 174 +++++++++++++++++
 tb/tb_adder_delay_meter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_meas_pkg.sv
// Shared types and helpers for the adder ring-loop delay meter.
//   meas_state_t : measurement sequencer states
//   DEF_*        : default parameter values for the top level
//   sat_inc      : saturating increment used by the ring edge counter
package adder_meas_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } meas_state_t;

  localparam int unsigned DEF_WIDTH       = 32;
  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_CH_W        = 2;
  localparam int unsigned DEF_WIN_W       = 16;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_SETTLE      = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Working width of sat_inc; counters up to this width are supported.
  localparam int unsigned SAT_W = 32;

  // Increment value, holding at max_value once reached.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] max_value);
    return (value >= max_value) ? value : value + SAT_W'(1);
  endfunction

endpackage

// File: rtl/meas_edge_sync.sv
// Ring tap selection, synchroniser and rising-edge detector.
//   clk, rst_n : clock and asynchronous active-low reset
//   ring_in    : asynchronous ring taps from the adder
//   ch_sel     : selected tap (driven from the latched channel)
//   rise_c     : combinational one-cycle pulse per synchronised rising edge
module meas_edge_sync #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CH_W        = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ring_in,
  input  logic [CH_W-1:0]   ch_sel,
  output logic              rise_c
);

  logic                   tap_c;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Tap mux; an out-of-range select reads as a quiet tap.
  always_comb begin
    tap_c = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) tap_c = ring_in[i];
    end
  end

  // Synchroniser chain followed by the history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tap_c};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/adder_delay_meter.sv
// Measurement controller for an instrumented adder ring loop.
// Drives registered operands into the adder, closes the ring through a
// selected tap for a programmable window and counts ring rising edges.
//   wb_clk_i, rst_n   : system clock, asynchronous active-low reset
//   start, abort      : request a measurement / cancel any measurement
//   mode              : 0 single-shot, 1 continuous
//   ch_sel, window    : ring tap select, window length in clocks (0 -> 1)
//   a_in, b_in        : operand requests
//   ring_in           : asynchronous ring taps
//   a_out, b_out      : registered operands to the adder
//   ring_en, busy     : ring loop enable, sequencer active
//   count, count_valid: last result, one-cycle update pulse
//   overflow          : sticky counter saturation flag
module adder_delay_meter
  import adder_meas_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned CH_W        = DEF_CH_W,
  parameter int unsigned WIN_W       = DEF_WIN_W,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SETTLE      = DEF_SETTLE,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [WIN_W-1:0]  window,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  input  logic [NUM_CH-1:0] ring_in,
  output logic [WIDTH-1:0]  a_out,
  output logic [WIDTH-1:0]  b_out,
  output logic              ring_en,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic              count_valid,
  output logic              overflow
);

  // One phase timer serves SETUP, RUN and DRAIN; wide enough for all three.
  localparam int unsigned      TMR_W     = (WIN_W > 8) ? WIN_W : 8;
  localparam logic [TMR_W-1:0] SETTLE_M1 = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] DRAIN_M1  = TMR_W'(SYNC_STAGES - 1);
  localparam logic [SAT_W-1:0] CNT_MAX   = SAT_W'((64'd1 << CNT_W) - 64'd1);

  meas_state_t       state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [WIN_W-1:0]  win_q;
  logic [CH_W-1:0]   ch_q;
  logic              mode_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rise_c;
  logic              count_en_c;
  logic              sat_hit_c;
  logic              accept_c;

  meas_edge_sync #(
    .NUM_CH      (NUM_CH),
    .CH_W        (CH_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk     (wb_clk_i),
    .rst_n   (rst_n),
    .ring_in (ring_in),
    .ch_sel  (ch_q),
    .rise_c  (rise_c)
  );

  // Next state and phase timer; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          timer_d = SETTLE_M1;
        end
      end
      SETUP: begin
        if (timer_q == '0) begin
          state_d = RUN;
          timer_d = TMR_W'(win_q) - TMR_W'(1);
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      RUN: begin
        if (timer_q == '0) begin
          state_d = DRAIN;
          timer_d = DRAIN_M1;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      DRAIN: begin
        if (timer_q == '0) begin
          state_d = DONE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      DONE: begin
        if (mode_q) begin
          state_d = SETUP;
          timer_d = SETTLE_M1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      timer_d = '0;
    end
  end

  // Edge counter: only edges surfacing during RUN or DRAIN are counted.
  always_comb begin
    accept_c   = (state_q == IDLE) && start && !abort;
    count_en_c = rise_c && ((state_q == RUN) || (state_q == DRAIN));
    sat_hit_c  = count_en_c && (&cnt_q);
    cnt_d      = cnt_q;
    if ((state_d == SETUP) && (state_q != SETUP)) begin
      cnt_d = '0;
    end else if (count_en_c) begin
      cnt_d = CNT_W'(sat_inc(SAT_W'(cnt_q), CNT_MAX));
    end
  end

  // State, latched request and registered outputs.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      win_q       <= '0;
      ch_q        <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      a_out       <= '0;
      b_out       <= '0;
      ring_en     <= 1'b0;
      busy        <= 1'b0;
      count       <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      ring_en     <= (state_d == RUN);
      busy        <= (state_d != IDLE);
      count_valid <= (state_d == DONE);
      // The final DRAIN cycle's edge lands in cnt_d, so load from it.
      if (state_d == DONE) count <= cnt_d;
      if (accept_c) begin
        a_out    <= a_in;
        b_out    <= b_in;
        ch_q     <= ch_sel;
        mode_q   <= mode;
        win_q    <= (window == '0) ? WIN_W'(1) : window;
        overflow <= 1'b0;
      end else if (sat_hit_c) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adder_delay_meter.sv
// Directed bench for adder_delay_meter with a result scoreboard.
// A default instance and a 4-bit-counter instance share all inputs.
module tb_adder_delay_meter;

  localparam int S  = 4;
  localparam int SY = 2;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, mode;
  logic [1:0]  ch_sel;
  logic [15:0] window;
  logic [31:0] a_in, b_in;
  logic [3:0]  ring_in = '0;

  logic [31:0] a_out, b_out, s_a_out, s_b_out;
  logic        ring_en, busy, count_valid, overflow;
  logic        s_ring_en, s_busy, s_count_valid, s_overflow;
  logic [15:0] count;
  logic [3:0]  s_count;

  adder_delay_meter dut (
    .wb_clk_i(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .ch_sel(ch_sel), .window(window), .a_in(a_in), .b_in(b_in), .ring_in(ring_in),
    .a_out(a_out), .b_out(b_out), .ring_en(ring_en), .busy(busy), .count(count),
    .count_valid(count_valid), .overflow(overflow)
  );

  adder_delay_meter #(.CNT_W(4)) dut_sat (
    .wb_clk_i(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .ch_sel(ch_sel), .window(window), .a_in(a_in), .b_in(b_in), .ring_in(ring_in),
    .a_out(s_a_out), .b_out(s_b_out), .ring_en(s_ring_en), .busy(s_busy), .count(s_count),
    .count_valid(s_count_valid), .overflow(s_overflow)
  );

  always #5 clk = ~clk;

  // Cycle counter and ring tap generator; tp[i] = clocks per toggle, 0 holds.
  int cyc = 0;
  int tp[4] = '{0, 0, 0, 0};
  int ph[4] = '{0, 0, 0, 0};
  int rise_log[4][$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (tp[i] != 0) begin
        if (ph[i] + 1 >= tp[i]) begin
          ph[i] <= 0;
          ring_in[i] <= ~ring_in[i];
          if (!ring_in[i]) rise_log[i].push_back(cyc + 1);
        end else begin
          ph[i] <= ph[i] + 1;
        end
      end
    end
  end

  typedef struct {
    int k;
    int ch;
    int w;
    bit cont;
    bit fresh;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;
  int   nvalid = 0;
  int   last_cnt = 0;
  bit   ovf16_m = 0;
  bit   ovf4_m = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Rising edge at tap level after posedge n reaches the history compare
  // SY cycles later; it counts if that cycle lies in RUN or DRAIN.
  function automatic int raw_edges(input int k, input int ch, input int w);
    int n = 0;
    for (int j = 0; j < rise_log[ch].size(); j++) begin
      if (rise_log[ch][j] >= k + S + 1 - SY && rise_log[ch][j] <= k + S + w) n++;
    end
    return n;
  endfunction

  task automatic observe();
    exp_t e, nx;
    int   raw;
    if (ring_en) en_cnt++;
    if (count_valid || s_count_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'(count_valid), 64'd0);
      end else begin
        e   = sb.pop_front();
        raw = raw_edges(e.k, e.ch, e.w);
        if (e.fresh) begin
          ovf16_m = 0;
          ovf4_m  = 0;
        end
        if (raw > 65535) ovf16_m = 1;
        if (raw > 15) ovf4_m = 1;
        last_cnt = (raw > 65535) ? 65535 : raw;
        chk("valid_cycle", 64'(cyc), 64'(e.k + 1 + S + e.w + SY));
        chk("valid_align", 64'(s_count_valid), 64'(count_valid));
        chk("count", 64'(count), 64'(last_cnt));
        chk("sat_count", 64'(s_count), 64'((raw > 15) ? 15 : raw));
        chk("overflow", 64'(overflow), 64'(ovf16_m));
        chk("sat_overflow", 64'(s_overflow), 64'(ovf4_m));
        nvalid++;
        if (e.cont) begin
          nx       = e;
          nx.k     = cyc;
          nx.fresh = 0;
          sb.push_back(nx);
        end
      end
    end
  endtask

  // Observe at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int ch, input int w, input bit md,
                          input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    ch_sel  = 2'(ch);
    window  = 16'(w);
    mode    = md;
    a_in    = a;
    b_in    = b;
    start   = 1'b1;
    e.k     = cyc;
    e.ch    = ch;
    e.w     = (w == 0) ? 1 : w;
    e.cont  = md;
    e.fresh = 1;
    sb.push_back(e);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    for (int i = 0; i < lim && sb.size() != 0; i++) tick();
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base, target;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
    ch_sel = '0; window = '0; a_in = '0; b_in = '0;
    repeat (3) tick();
    chk("rst_a_out", 64'(a_out), 64'd0);
    chk("rst_b_out", 64'(b_out), 64'd0);
    chk("rst_ring_en", 64'(ring_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_count_valid", 64'(count_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    while (cyc < 10) tick();

    // Single-shot, tap 1 toggling every 4 clocks, window 64.
    tp[1] = 4;
    base = en_cnt;
    do_start(1, 64, 0, 32'h1234_5678, 32'h0F0F_0F0F);
    chk("t1_a_out", 64'(a_out), 64'h1234_5678);
    chk("t1_b_out", 64'(b_out), 64'h0F0F_0F0F);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done("t1_timeout", 200);
    chk("t1_ring_en_cycles", 64'(en_cnt - base), 64'd64);
    chk("t1_idle", 64'(busy), 64'd0);

    // Saturation of the 4-bit instance: tap 0 toggles every clock.
    tp[1] = 0;
    tp[0] = 1;
    base = en_cnt;
    do_start(0, 64, 0, 32'h1, 32'h2);
    wait_done("t2_timeout", 200);
    chk("t2_ring_en_cycles", 64'(en_cnt - base), 64'd64);
    chk("t2_sat_ovf_sticky", 64'(s_overflow), 64'd1);
    tp[0] = 0;
    repeat (3) tick();

    // Window 0 on a steady tap; overflow clears on the accepted start.
    base = en_cnt;
    do_start(1, 0, 0, 32'hDEAD_BEEF, 32'h0000_0001);
    chk("t3_a_out", 64'(a_out), 64'hDEAD_BEEF);
    chk("t3_b_out", 64'(b_out), 64'h0000_0001);
    chk("t3_sat_ovf_clear", 64'(s_overflow), 64'd0);
    wait_done("t3_timeout", 100);
    chk("t3_ring_en_cycles", 64'(en_cnt - base), 64'd1);

    // Continuous mode, ring period 4, window 16; abort mid-RUN.
    tp[1] = 2;
    target = nvalid + 3;
    do_start(1, 16, 1, 32'h5, 32'h6);
    for (int i = 0; i < 200 && nvalid < target; i++) tick();
    chk("t4_loops", 64'(nvalid), 64'(target));
    for (int i = 0; i < 50 && !ring_en; i++) tick();
    repeat (5) tick();
    chk("t4_in_run", 64'(ring_en), 64'd1);
    abort = 1'b1;
    sb.delete();
    tick();
    abort = 1'b0;
    mode = 1'b0;
    chk("t4_abort_busy", 64'(busy), 64'd0);
    chk("t4_abort_ring_en", 64'(ring_en), 64'd0);
    chk("t4_abort_count", 64'(count), 64'(last_cnt));
    repeat (40) tick();
    chk("t4_no_more_valid", 64'(count), 64'(last_cnt));

    // Asynchronous reset during RUN, then a fresh measurement.
    tp[1] = 4;
    do_start(1, 64, 0, 32'hA, 32'hB);
    for (int i = 0; i < 50 && !ring_en; i++) tick();
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_ring_en", 64'(ring_en), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_count", 64'(count), 64'd0);
    chk("t5_rst_count_valid", 64'(count_valid), 64'd0);
    chk("t5_rst_a_out", 64'(a_out), 64'd0);
    sb.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    do_start(1, 16, 0, 32'hC, 32'hD);
    chk("t5_restart_busy", 64'(busy), 64'd1);
    wait_done("t5_timeout", 100);

    // Unselected tap toggling; start and ch_sel changes while busy.
    tp[1] = 0;
    tp[3] = 1;
    do_start(2, 32, 0, 32'h11, 32'h22);
    repeat (10) tick();
    ch_sel = 2'd3;
    a_in   = 32'h99;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("t6_a_out_held", 64'(a_out), 64'h11);
    chk("t6_busy", 64'(busy), 64'd1);
    wait_done("t6_timeout", 100);
    tp[3] = 0;
    repeat (3) tick();

    // Edges only during SETUP on the selected tap.
    tp[0] = 1;
    do_start(0, 8, 0, 32'h33, 32'h44);
    tick();
    tp[0] = 0;
    wait_done("t7_timeout", 100);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
